cen_monitor: RTL and testbench

Monitors a clock-enable pulse stream, such as one produced by the team's divider blocks, and checks that it arrives at a constant period. Each interval between `cen` pulses is measured in `clk` cycles and compared with an expected period. The block reports lock status and pulses an error output on a mismatch or a timeout. It sits beside every derived-enable consumer (CPU, sound, video) as a run-time and simulation checker.

---
 rtl/cen_monitor_pkg.sv | 16 +
 rtl/cen_monitor.sv | 112 +++++++++++
 tb/tb_cen_monitor.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cen_monitor_pkg.sv
// Shared types for the clock-enable period monitor: FSM states and the
// interval-counter width helper.
package cen_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } state_e;

  // Bits needed to hold a period of up to max_period clk cycles.
  function automatic int cnt_width(input int max_period);
    return $clog2(max_period + 1);
  endfunction

endpackage

// File: rtl/cen_monitor.sv
// Measures the clk-cycle interval between cen pulses, tracks lock against an
// expected period, and pulses error on a mismatch while locked or on a timeout.
module cen_monitor
  import cen_monitor_pkg::*;
#(
  parameter int EXPECTED   = 4,
  parameter int TOLERANCE  = 0,
  parameter int LOCK_COUNT = 4,
  parameter int MAX_PERIOD = 256,
  localparam int W         = cnt_width(MAX_PERIOD)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cen,
  output logic [W-1:0] period,
  output logic         period_valid,
  output logic         locked,
  output logic         error
);

  localparam int GW = $clog2(LOCK_COUNT + 1);

  state_e        state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [GW-1:0] good_q, good_d;
  logic [W-1:0]  period_q, period_d;
  logic          period_valid_q, period_valid_d;
  logic          locked_q, locked_d;
  logic          error_q, error_d;
  logic [W-1:0]  meas;

  // One extra bit keeps the signed difference exact over the whole range.
  function automatic logic in_tol(input logic [W-1:0] m);
    logic signed [W:0] diff;
    diff = $signed({1'b0, m}) - $signed((W+1)'(EXPECTED));
    if (diff[W]) diff = -diff;
    return diff <= $signed((W+1)'(TOLERANCE));
  endfunction

  function automatic logic [GW-1:0] sat_inc(input logic [GW-1:0] g);
    return (g == GW'(LOCK_COUNT)) ? g : g + 1'b1;
  endfunction

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    good_d         = good_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    error_d        = 1'b0;
    meas           = cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cen) state_d = ACQUIRE;
      end
      ACQUIRE, LOCKED: begin
        if (cen) begin
          cnt_d          = '0;
          period_d       = meas;
          period_valid_d = 1'b1;
          if (in_tol(meas)) begin
            good_d = sat_inc(good_q);
            if (state_q == ACQUIRE && good_d == GW'(LOCK_COUNT)) state_d = LOCKED;
          end else begin
            good_d = '0;
            if (state_q == LOCKED) begin
              error_d = 1'b1;
              state_d = ACQUIRE;
            end
          end
        end else if (cnt_q == W'(MAX_PERIOD - 1)) begin
          // Interval longer than measurable: give up and wait for a fresh cen.
          error_d = 1'b1;
          state_d = IDLE;
          good_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      good_q         <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      good_q         <= good_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      error_q        <= error_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign error        = error_q;

endmodule

// File: tb/tb_cen_monitor.sv
// Directed, table-driven bench for cen_monitor with EXPECTED=4, TOLERANCE=0,
// LOCK_COUNT=4, MAX_PERIOD=16.
module tb_cen_monitor;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cen = 1'b0;
  logic [W-1:0] period;
  logic         period_valid;
  logic         locked;
  logic         error;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       cen;
    logic       pv;
    int         per;
    logic       lk;
    logic       er;
  } vec_t;

  vec_t tbl[$];

  cen_monitor #(
    .EXPECTED  (4),
    .TOLERANCE (0),
    .LOCK_COUNT(4),
    .MAX_PERIOD(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cen         (cen),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .error       (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic v);
    cen = v;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic c, input logic pv, input int per, input logic lk, input logic er);
    vec_t v;
    v.cen = c; v.pv = pv; v.per = per; v.lk = lk; v.er = er;
    tbl.push_back(v);
  endtask

  task automatic add_gap(input int n, input int per, input logic lk);
    for (int k = 0; k < n; k++) add(1'b0, 1'b0, per, lk, 1'b0);
  endtask

  task automatic chk_all(input string tag, input logic pv, input int per, input logic lk, input logic er);
    chk({tag, " pv"}, int'(period_valid), int'(pv));
    chk({tag, " period"}, int'(period), per);
    chk({tag, " locked"}, int'(locked), int'(lk));
    chk({tag, " error"}, int'(error), int'(er));
  endtask

  initial begin
    // Clean stream: first cen only starts the interval, lock on the 4th measurement.
    add(1'b1, 1'b0, 0, 1'b0, 1'b0);
    add_gap(3, 0, 1'b0); add(1'b1, 1'b1, 4, 1'b0, 1'b0);
    add_gap(3, 4, 1'b0); add(1'b1, 1'b1, 4, 1'b0, 1'b0);
    add_gap(3, 4, 1'b0); add(1'b1, 1'b1, 4, 1'b0, 1'b0);
    add_gap(3, 4, 1'b0); add(1'b1, 1'b1, 4, 1'b1, 1'b0);
    // Glitch of 5 while locked, then re-lock after four good intervals.
    add_gap(4, 4, 1'b1); add(1'b1, 1'b1, 5, 1'b0, 1'b1);
    add_gap(3, 5, 1'b0); add(1'b1, 1'b1, 4, 1'b0, 1'b0);
    add_gap(3, 4, 1'b0); add(1'b1, 1'b1, 4, 1'b0, 1'b0);
    add_gap(3, 4, 1'b0); add(1'b1, 1'b1, 4, 1'b0, 1'b0);
    add_gap(3, 4, 1'b0); add(1'b1, 1'b1, 4, 1'b1, 1'b0);
    // Timeout: 16 cycles after the last cen error pulses and locked drops.
    add_gap(15, 4, 1'b1);
    add(1'b0, 1'b0, 4, 1'b0, 1'b1);
    add(1'b0, 1'b0, 4, 1'b0, 1'b0);
    add(1'b1, 1'b0, 4, 1'b0, 1'b0);
    // Boundary: exact 16-cycle interval, then a 1-cycle interval.
    add_gap(15, 4, 1'b0); add(1'b1, 1'b1, 16, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1, 1'b0, 1'b0);
    // Three good, a 1-cycle interval clears good, then four good to lock.
    add_gap(3, 1, 1'b0); add(1'b1, 1'b1, 4, 1'b0, 1'b0);
    add_gap(3, 4, 1'b0); add(1'b1, 1'b1, 4, 1'b0, 1'b0);
    add_gap(3, 4, 1'b0); add(1'b1, 1'b1, 4, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1, 1'b0, 1'b0);
    add_gap(3, 1, 1'b0); add(1'b1, 1'b1, 4, 1'b0, 1'b0);
    add_gap(3, 4, 1'b0); add(1'b1, 1'b1, 4, 1'b0, 1'b0);
    add_gap(3, 4, 1'b0); add(1'b1, 1'b1, 4, 1'b0, 1'b0);
    add_gap(3, 4, 1'b0); add(1'b1, 1'b1, 4, 1'b1, 1'b0);

    // Reset held with cen toggling: outputs stay at zero.
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(i[0]);
      chk_all($sformatf("reset%0d", i), 1'b0, 0, 1'b0, 1'b0);
    end
    cen = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].cen);
      chk_all($sformatf("row%0d", i), tbl[i].pv, tbl[i].per, tbl[i].lk, tbl[i].er);
    end

    // Mid-interval reset while locked clears everything at once.
    step(1'b0);
    step(1'b0);
    #2 rst_n = 1'b0;
    #1 chk_all("midrst", 1'b0, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1);
    chk_all("restart first", 1'b0, 0, 1'b0, 1'b0);
    for (int g = 1; g <= 4; g++) begin
      for (int k = 0; k < 3; k++) step(1'b0);
      step(1'b1);
      chk_all($sformatf("restart%0d", g), 1'b1, 4, (g == 4), 1'b0);
    end
    step(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
